// File: rtl/ddr3_ui_pkg.sv
// Shared constants and helpers for the MIG 7-series DDR3 user (app) interface.
package ddr3_ui_pkg;

  localparam logic [2:0]  CMD_WRITE      = 3'b000;
  localparam logic [2:0]  CMD_READ       = 3'b001;
  localparam int unsigned APP_DATA_WIDTH = 512;
  localparam int unsigned APP_MASK_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH     = 29;
  localparam int unsigned ADDR_INC       = 8;
  localparam int unsigned PIX_BYTES      = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_DONE
  } wr_state_e;

  // Byte mask for a word holding n_pix pixels: used bytes 0, unused bytes 1.
  function automatic logic [APP_MASK_WIDTH-1:0] partial_mask(input logic [4:0] n_pix);
    logic [APP_MASK_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < APP_MASK_WIDTH; i++) begin
      m[i] = (i >= PIX_BYTES * n_pix);
    end
    return m;
  endfunction

endpackage

// File: rtl/ddr3_row_writer_if.sv
// Pixel stream plus MIG app write channel seen by the row writer.
interface ddr3_row_writer_if #(
  parameter int unsigned ADDR_WIDTH = 29
);

  logic [31:0]                               pix_data;
  logic                                      pix_valid;
  logic                                      pix_ready;
  logic [ADDR_WIDTH-1:0]                     app_addr;
  logic [2:0]                                app_cmd;
  logic                                      app_en;
  logic                                      app_rdy;
  logic [ddr3_ui_pkg::APP_DATA_WIDTH-1:0]    app_wdf_data;
  logic [ddr3_ui_pkg::APP_MASK_WIDTH-1:0]    app_wdf_mask;
  logic                                      app_wdf_wren;
  logic                                      app_wdf_end;
  logic                                      app_wdf_rdy;

  modport master (
    input  pix_data, pix_valid, app_rdy, app_wdf_rdy,
    output pix_ready, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output pix_data, pix_valid, app_rdy, app_wdf_rdy,
    input  pix_ready, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

endinterface

// File: rtl/pix_word_packer.sv
// Packs 32-bit pixels into a 512-bit app word, pixel 0 in the LSBs.
module pix_word_packer
  import ddr3_ui_pkg::*;
#(
  parameter int unsigned PIX_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      flush,
  input  logic [PIX_WIDTH-1:0]      pix,
  output logic                      word_full,
  output logic [APP_DATA_WIDTH-1:0] word_data,
  output logic [APP_MASK_WIDTH-1:0] word_mask
);

  localparam int unsigned SLOTS = APP_DATA_WIDTH / PIX_WIDTH;

  logic [4:0]                slot_q, slot_d;
  logic [APP_DATA_WIDTH-1:0] data_q, data_d;
  logic [APP_MASK_WIDTH-1:0] mask_q, mask_d;

  assign word_full = push & ((slot_q == 5'(SLOTS - 1)) | flush);
  assign word_data = data_q;
  assign word_mask = mask_q;

  // Data is zeroed on clear so bytes beyond a partial word read back as 0.
  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    mask_d = mask_q;
    if (clear) begin
      slot_d = '0;
      data_d = '0;
    end else if (push) begin
      data_d[PIX_WIDTH*int'(slot_q) +: PIX_WIDTH] = pix;
      slot_d = slot_q + 5'd1;
      if (word_full) begin
        mask_d = partial_mask(slot_q + 5'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/ddr3_row_writer.sv
// Writes one stitched frame per start pulse into DDR3 through the MIG app
// interface, one 512-bit word per command, rows contiguous from BASE_ADDR.
module ddr3_row_writer
  import ddr3_ui_pkg::*;
#(
  parameter int unsigned WIDTH      = 1100,
  parameter int unsigned HEIGHT     = 1100,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned PIX_WIDTH  = 32
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic start,
  input  logic init_calib_complete,
  output logic busy,
  output logic frame_done,
  ddr3_row_writer_if.master bus
);

  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  wr_state_e        state_q, state_d;
  addr_t            addr_q, addr_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             last_q, last_d;
  logic             cmd_done_q, cmd_done_d;
  logic             dat_done_q, dat_done_d;

  logic                      pk_clear;
  logic                      pix_accept;
  logic                      row_end;
  logic                      word_full;
  logic                      en;
  logic                      wren;
  logic                      cmd_fire;
  logic                      dat_fire;
  logic [APP_DATA_WIDTH-1:0] word_data;
  logic [APP_MASK_WIDTH-1:0] word_mask;

  assign row_end    = (col_q == COL_W'(WIDTH - 1));
  assign pix_accept = (state_q == S_FILL) & bus.pix_valid;
  assign en         = (state_q == S_ISSUE) & ~cmd_done_q;
  assign wren       = (state_q == S_ISSUE) & ~dat_done_q;
  assign cmd_fire   = en & bus.app_rdy;
  assign dat_fire   = wren & bus.app_wdf_rdy;

  assign bus.pix_ready    = (state_q == S_FILL);
  assign bus.app_addr     = addr_q;
  assign bus.app_cmd      = CMD_WRITE;
  assign bus.app_en       = en;
  assign bus.app_wdf_wren = wren;
  assign bus.app_wdf_end  = wren;
  assign bus.app_wdf_data = word_data;
  assign bus.app_wdf_mask = word_mask;
  assign busy             = (state_q == S_FILL) | (state_q == S_ISSUE);
  assign frame_done       = (state_q == S_DONE);

  pix_word_packer #(
    .PIX_WIDTH (PIX_WIDTH)
  ) u_packer (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .push      (pix_accept),
    .flush     (row_end),
    .pix       (bus.pix_data),
    .word_full (word_full),
    .word_data (word_data),
    .word_mask (word_mask)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    last_d     = last_q;
    cmd_done_d = cmd_done_q;
    dat_done_d = dat_done_q;
    pk_clear   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pk_clear = 1'b1;
        if (start && init_calib_complete) begin
          state_d    = S_FILL;
          addr_d     = addr_t'(BASE_ADDR);
          col_d      = '0;
          row_d      = '0;
          last_d     = 1'b0;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
        end
      end
      S_FILL: begin
        if (pix_accept) begin
          if (row_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_W'(HEIGHT - 1)) begin
              last_d = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          if (word_full) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Command and data may complete in either order; retire the word
        // only once both sides have been accepted.
        if (cmd_fire) cmd_done_d = 1'b1;
        if (dat_fire) dat_done_d = 1'b1;
        if ((cmd_done_q | cmd_fire) & (dat_done_q | dat_fire)) begin
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          addr_d     = addr_q + addr_t'(ADDR_INC);
          pk_clear   = 1'b1;
          state_d    = last_q ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      last_q     <= 1'b0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      last_q     <= last_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
    end
  end

endmodule

// File: tb/tb_ddr3_row_writer.sv
// Directed bench for ddr3_row_writer with a scoreboard of expected app writes.
module tb_ddr3_row_writer;

  localparam int unsigned W = 20;
  localparam int unsigned H = 2;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic start;
  logic init_calib_complete;
  logic busy;
  logic frame_done;

  int total = 0;
  int bad   = 0;

  ddr3_row_writer_if #(.ADDR_WIDTH(29)) bus();

  ddr3_row_writer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .BASE_ADDR  (0),
    .ADDR_WIDTH (29),
    .PIX_WIDTH  (32)
  ) dut (
    .sys_clk             (sys_clk),
    .rst_n               (rst_n),
    .start               (start),
    .init_calib_complete (init_calib_complete),
    .busy                (busy),
    .frame_done          (frame_done),
    .bus                 (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [28:0]  exp_addr_q[$];
  logic [511:0] exp_data_q[$];
  logic [63:0]  exp_mask_q[$];
  logic [31:0]  src_q[$];

  logic [511:0] m_word;
  logic [28:0]  m_addr;
  int           m_slot, m_col, m_acc;
  int           n_cmd, n_dat, n_done;
  logic         prev_busy;
  bit           rand_valid;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_mask_q.delete();
    src_q.delete();
    m_word = '0;
    m_addr = '0;
    m_slot = 0;
    m_col  = 0;
    m_acc  = 0;
    n_cmd  = 0;
    n_dat  = 0;
    n_done = 0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    m_word[32*m_slot +: 32] = d;
    m_slot++;
    m_col++;
    m_acc++;
    if (m_slot == 16 || m_col == int'(W)) begin
      exp_addr_q.push_back(m_addr);
      exp_data_q.push_back(m_word);
      exp_mask_q.push_back((m_slot == 16) ? 64'h0 : ({64{1'b1}} << (4 * m_slot)));
      m_addr = m_addr + 29'd8;
      m_word = '0;
      m_slot = 0;
      if (m_col == int'(W)) m_col = 0;
    end
  endtask

  // Observe at the falling edge, then drive the source just after the rising edge.
  task automatic tick();
    @(negedge sys_clk);
    if (bus.app_en && bus.app_rdy) begin
      n_cmd++;
      chk("cmd_expected", exp_addr_q.size() > 0, 1'b1);
      if (exp_addr_q.size() > 0) chk("cmd_addr", bus.app_addr, exp_addr_q.pop_front());
      chk("cmd_code", bus.app_cmd, 3'b000);
    end
    if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
      n_dat++;
      chk("data_expected", exp_data_q.size() > 0, 1'b1);
      if (exp_data_q.size() > 0) begin
        chk("wdf_data", bus.app_wdf_data, exp_data_q.pop_front());
        chk("wdf_mask", bus.app_wdf_mask, exp_mask_q.pop_front());
      end
      chk("wdf_end", bus.app_wdf_end, 1'b1);
    end
    if (frame_done) begin
      n_done++;
      chk("busy_at_done", busy, 1'b0);
      chk("busy_before_done", prev_busy, 1'b1);
    end
    prev_busy = busy;
    if (bus.pix_valid && bus.pix_ready) begin
      model_accept(bus.pix_data);
      void'(src_q.pop_front());
    end
    @(posedge sys_clk);
    #1;
    if (src_q.size() > 0) begin
      bus.pix_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = src_q[0];
    end else begin
      bus.pix_valid = 1'b0;
      bus.pix_data  = '0;
    end
  endtask

  task automatic start_frame(input int first);
    model_reset();
    for (int i = 0; i < int'(W * H); i++) src_q.push_back(32'(first + i));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    int k = 0;
    while (n_done == 0 && k < 600) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, n_done != 0, 1'b1);
    repeat (3) tick();
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_cmd_count"}, n_cmd, 4);
    chk({tag, "_data_count"}, n_dat, 4);
    chk({tag, "_left_over"}, exp_addr_q.size() + exp_data_q.size(), 0);
  endtask

  task automatic wait_for(input bit want_wren, input string tag);
    int k = 0;
    while (!(want_wren ? bus.app_wdf_wren : bus.app_en) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_seen"}, want_wren ? bus.app_wdf_wren : bus.app_en, 1'b1);
  endtask

  initial begin
    logic [28:0]  a0;
    logic [511:0] d0;
    logic [63:0]  mk0;
    int           k;

    rst_n               = 1'b0;
    start               = 1'b0;
    init_calib_complete = 1'b1;
    bus.pix_valid       = 1'b0;
    bus.pix_data        = '0;
    bus.app_rdy         = 1'b1;
    bus.app_wdf_rdy     = 1'b1;
    rand_valid          = 1'b0;
    prev_busy           = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_app_en", bus.app_en, 1'b0);
    chk("rst_wren", bus.app_wdf_wren, 1'b0);
    chk("rst_wdf_end", bus.app_wdf_end, 1'b0);
    chk("rst_addr", bus.app_addr, 29'd0);
    chk("rst_cmd", bus.app_cmd, 3'd0);
    chk("rst_data", bus.app_wdf_data, 512'd0);
    chk("rst_mask", bus.app_wdf_mask, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_pix_ready", bus.pix_ready, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic frame, MIG always ready.
    start_frame(1);
    end_frame("basic");

    // Command side stalled for five cycles.
    bus.app_rdy = 1'b0;
    start_frame(1);
    wait_for(1'b0, "crdy_en");
    a0 = bus.app_addr;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("crdy_en_held", bus.app_en, 1'b1);
      chk("crdy_wren_dropped", bus.app_wdf_wren, 1'b0);
      chk("crdy_addr_stable", bus.app_addr, a0);
      chk("crdy_pix_ready", bus.pix_ready, 1'b0);
    end
    bus.app_rdy = 1'b1;
    tick();
    chk("crdy_en_drop", bus.app_en, 1'b0);
    end_frame("crdy");

    // Data side stalled for three cycles.
    bus.app_wdf_rdy = 1'b0;
    start_frame(1);
    wait_for(1'b1, "drdy_wren");
    d0  = bus.app_wdf_data;
    mk0 = bus.app_wdf_mask;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drdy_en_dropped", bus.app_en, 1'b0);
      chk("drdy_wren_held", bus.app_wdf_wren, 1'b1);
      chk("drdy_data_stable", bus.app_wdf_data, d0);
      chk("drdy_mask_stable", bus.app_wdf_mask, mk0);
    end
    bus.app_wdf_rdy = 1'b1;
    tick();
    chk("drdy_wren_drop", bus.app_wdf_wren, 1'b0);
    end_frame("drdy");

    // Start before calibration completes is ignored.
    init_calib_complete = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nocal_busy", busy, 1'b0);
      chk("nocal_pix_ready", bus.pix_ready, 1'b0);
    end
    init_calib_complete = 1'b1;
    start_frame(201);
    end_frame("cal");

    // Asynchronous reset after ten pixels.
    start_frame(1);
    k = 0;
    while (m_acc < 10 && k < 100) begin
      tick();
      k++;
    end
    chk("rst_mid_pixels", m_acc, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_app_en", bus.app_en, 1'b0);
    chk("arst_wren", bus.app_wdf_wren, 1'b0);
    chk("arst_addr", bus.app_addr, 29'd0);
    chk("arst_data", bus.app_wdf_data, 512'd0);
    chk("arst_mask", bus.app_wdf_mask, 64'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pix_ready", bus.pix_ready, 1'b0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(101);
    end_frame("after_rst");

    // Random pixel gaps, stray start and calibration drop mid-frame.
    rand_valid = 1'b1;
    start_frame(1);
    repeat (6) tick();
    start = 1'b1;
    init_calib_complete = 1'b0;
    tick();
    start = 1'b0;
    end_frame("rand");
    rand_valid = 1'b0;
    init_calib_complete = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
